sliding_window_stream: RTL and testbench

- Frame-aware successor to the raw sliding-window shift register.
- Accepts a raster pixel stream with a valid qualifier and start-of-frame marker, and tracks row/column position.
- Emits a WINDOW_HEIGHT x WINDOW_WIDTH neighbourhood only when the window lies entirely inside the current frame: no line wrap, no frame mixing.
- Feeds the gradient/optical-flow kernels that need per-window valid and position tags.

---
 rtl/sliding_window_stream.sv | 135 +++++++++++++
 tb/tb_sliding_window_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sliding_window_stream.sv
// Purpose: frame-aware sliding-window extractor; tags each pixel with its (row,col) and emits full in-frame windows.
// Latency: 1 cycle from the accepting clk edge to out_valid/window_out/out_row/out_col/frame_done.
// Backpressure: none; a pixel is taken on every in_valid edge and the consumer must take every out_valid.
module sliding_window_stream #(
   parameter int WINDOW_WIDTH    = 3,
   parameter int WINDOW_HEIGHT   = 3,
   parameter int IN_WIDTH        = 8,
   parameter int PIXELS_PER_LINE = 640,
   parameter int LINES_PER_FRAME = 480,
   parameter int COL_BITS        = (PIXELS_PER_LINE > 1) ? $clog2(PIXELS_PER_LINE) : 1,
   parameter int ROW_BITS        = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          in_valid,
   input  logic                                          in_sof,
   input  logic [IN_WIDTH-1:0]                           value_in,
   output logic                                          out_valid,
   output logic [WINDOW_WIDTH*WINDOW_HEIGHT*IN_WIDTH-1:0] window_out,
   output logic [ROW_BITS-1:0]                           out_row,
   output logic [COL_BITS-1:0]                           out_col,
   output logic                                          frame_done
);

   // History depth: newest pixel at index 0, the window's top-left pixel at the far end.
   localparam int DEPTH = PIXELS_PER_LINE * (WINDOW_HEIGHT - 1) + WINDOW_WIDTH;
   localparam int WIN_BITS = WINDOW_WIDTH * WINDOW_HEIGHT * IN_WIDTH;

   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(PIXELS_PER_LINE - 1);
   localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(LINES_PER_FRAME - 1);
   localparam logic [COL_BITS-1:0] MIN_COL  = COL_BITS'(WINDOW_WIDTH - 1);
   localparam logic [ROW_BITS-1:0] MIN_ROW  = ROW_BITS'(WINDOW_HEIGHT - 1);

   // Position of the next pixel to be accepted.
   logic [COL_BITS-1:0] col;
   logic [ROW_BITS-1:0] row;

   // Tag of the pixel currently offered and the position that follows it.
   logic [COL_BITS-1:0] tag_col;
   logic [ROW_BITS-1:0] tag_row;
   logic [COL_BITS-1:0] col_nxt;
   logic [ROW_BITS-1:0] row_nxt;

   logic                tag_in_window;
   logic                tag_is_last;

   logic [IN_WIDTH-1:0] hist [DEPTH];
   logic [WIN_BITS-1:0] win_nxt;

   // Start-of-frame overrides the counters so a truncated frame restarts cleanly at (0,0).
   always_comb begin
      tag_col = col;
      tag_row = row;
      if (in_sof) begin
         tag_col = '0;
         tag_row = '0;
      end
   end

   // Raster advance from the tag: column wraps at line end, row wraps at frame end.
   always_comb begin
      col_nxt = tag_col + COL_BITS'(1);
      row_nxt = tag_row;
      if (tag_col == LAST_COL) begin
         col_nxt = '0;
         if (tag_row == LAST_ROW) begin
            row_nxt = '0;
         end else begin
            row_nxt = tag_row + ROW_BITS'(1);
         end
      end
   end

   // A window is complete only once enough rows and columns of this frame exist above/left of the tag,
   // which also rules out line wrap and stale pixels from an earlier frame.
   always_comb begin
      tag_in_window = (tag_row >= MIN_ROW) && (tag_col >= MIN_COL);
      tag_is_last   = (tag_row == LAST_ROW) && (tag_col == LAST_COL);
   end

   // Position counters follow accepted pixels only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         col <= col_nxt;
         row <= row_nxt;
      end
   end

   // Pixel history shifts on accepted pixels; contents never need clearing since they are gated by the tag.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         hist[0] <= value_in;
         for (int i = 1; i < DEPTH; i++) begin
            hist[i] <= hist[i-1];
         end
      end
   end

   // Window taps are taken from the history as it will look after this pixel is shifted in,
   // so the incoming pixel itself is element 0.
   for (genvar r = 0; r < WINDOW_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < WINDOW_WIDTH; c++) begin : g_col
         localparam int K   = r * WINDOW_WIDTH + c;
         localparam int IDX = r * PIXELS_PER_LINE + c;
         if (IDX == 0) begin : g_newest
            assign win_nxt[K*IN_WIDTH +: IN_WIDTH] = value_in;
         end else begin : g_hist
            assign win_nxt[K*IN_WIDTH +: IN_WIDTH] = hist[IDX-1];
         end
      end
   end

   // Output register: valid/done pulse every cycle, payload only updates on a valid window.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         window_out <= '0;
         out_row    <= '0;
         out_col    <= '0;
      end else begin
         out_valid  <= in_valid && tag_in_window;
         frame_done <= in_valid && tag_is_last;
         if (in_valid && tag_in_window) begin
            window_out <= win_nxt;
            out_row    <= tag_row;
            out_col    <= tag_col;
         end
      end
   end

endmodule

// File: tb/tb_sliding_window_stream.sv
// Bench for sliding_window_stream with a 4x4 frame and a 3x3 window.
// Expected windows come from a frame image indexed by (row,col), pushed to a scoreboard on acceptance.
// Every cycle checks out_valid/frame_done timing; valid windows are popped and compared.
module tb_sliding_window_stream;

   localparam int W   = 3;
   localparam int H   = 3;
   localparam int IW  = 8;
   localparam int PPL = 4;
   localparam int LPF = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_sof;
   logic [IW-1:0]    value_in;
   logic             out_valid;
   logic [W*H*IW-1:0] window_out;
   logic [1:0]       out_row;
   logic [1:0]       out_col;
   logic             frame_done;

   sliding_window_stream #(
      .WINDOW_WIDTH(W), .WINDOW_HEIGHT(H), .IN_WIDTH(IW),
      .PIXELS_PER_LINE(PPL), .LINES_PER_FRAME(LPF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .value_in(value_in),
      .out_valid(out_valid), .window_out(window_out), .out_row(out_row), .out_col(out_col),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W*H*IW-1:0] win;
      int                row;
      int                col;
   } sb_t;

   sb_t sb [$];

   int n_tests = 0;
   int n_fail  = 0;

   // Per-phase observations
   int n_valid = 0;
   int n_done  = 0;
   int first_row = -1;
   int first_col = -1;
   logic [W*H*IW-1:0] win22;

   // Reference model state
   logic [IW-1:0] img [LPF][PPL];
   int mrow = 0;
   int mcol = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Model + monitor
   logic          s_rst, s_vld, s_sof;
   logic [IW-1:0] s_val;
   int            tr, tc;
   logic          e_vld, e_done;
   sb_t           ent, got_ent;

   always @(posedge clk) begin
      s_rst = rst_n;
      s_vld = in_valid;
      s_sof = in_sof;
      s_val = value_in;
      e_vld = 1'b0;
      e_done = 1'b0;
      if (!s_rst) begin
         mrow = 0;
         mcol = 0;
      end else if (s_vld) begin
         tr = s_sof ? 0 : mrow;
         tc = s_sof ? 0 : mcol;
         img[tr][tc] = s_val;
         if (tr >= H-1 && tc >= W-1) begin
            e_vld = 1'b1;
            ent.win = '0;
            for (int r = 0; r < H; r++)
               for (int c = 0; c < W; c++)
                  ent.win[(r*W+c)*IW +: IW] = img[tr-r][tc-c];
            ent.row = tr;
            ent.col = tc;
            sb.push_back(ent);
         end
         e_done = (tr == LPF-1) && (tc == PPL-1);
         if (tc == PPL-1) begin
            mcol = 0;
            mrow = (tr == LPF-1) ? 0 : tr + 1;
         end else begin
            mcol = tc + 1;
            mrow = tr;
         end
      end
      #1;
      if (!s_rst) begin
         chk("rst_out_valid",  128'(out_valid),  128'(0));
         chk("rst_frame_done", 128'(frame_done), 128'(0));
         chk("rst_window",     128'(window_out), 128'(0));
         chk("rst_out_row",    128'(out_row),    128'(0));
         chk("rst_out_col",    128'(out_col),    128'(0));
      end else begin
         chk("out_valid",  128'(out_valid),  128'(e_vld));
         chk("frame_done", 128'(frame_done), 128'(e_done));
         if (out_valid) begin
            if (first_row < 0) begin
               first_row = int'(out_row);
               first_col = int'(out_col);
            end
            n_valid++;
            if (frame_done) n_done++;
            if (out_row == 2'd2 && out_col == 2'd2) win22 = window_out;
            if (sb.size() == 0) begin
               chk("unexpected_window", 128'(out_valid), 128'(0));
            end else begin
               got_ent = sb.pop_front();
               chk("window",  128'(window_out), 128'(got_ent.win));
               chk("out_row", 128'(out_row),    128'(got_ent.row));
               chk("out_col", 128'(out_col),    128'(got_ent.col));
            end
         end
      end
   end

   task automatic send(input logic [IW-1:0] v, input logic sof);
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      value_in = v;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
         value_in = $urandom_range(0, 255);
      end
   endtask

   task automatic frame(input logic [IW-1:0] base, input logic sof, input logic gaps);
      for (int r = 0; r < LPF; r++)
         for (int c = 0; c < PPL; c++) begin
            send(base + IW'(r*16 + c), sof && r == 0 && c == 0);
            if (gaps) idle($urandom_range(1, 3));
         end
   endtask

   task automatic clear_obs();
      n_valid = 0;
      n_done = 0;
      first_row = -1;
      first_col = -1;
      win22 = '1;
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_sof = 1'b0;
      value_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Continuous frame
      clear_obs();
      frame(8'h00, 1'b1, 1'b0);
      idle(3);
      chk("p1_valid_count", 128'(n_valid), 128'(4));
      chk("p1_done_count",  128'(n_done),  128'(1));
      chk("p1_first_row",   128'(first_row), 128'(2));
      chk("p1_first_col",   128'(first_col), 128'(2));
      chk("p1_e0", 128'(win22[0*IW +: IW]), 128'(8'h22));
      chk("p1_e4", 128'(win22[4*IW +: IW]), 128'(8'h11));
      chk("p1_e8", 128'(win22[8*IW +: IW]), 128'(8'h00));

      // Same frame with random idle gaps
      clear_obs();
      frame(8'h00, 1'b1, 1'b1);
      idle(3);
      chk("p2_valid_count", 128'(n_valid), 128'(4));
      chk("p2_done_count",  128'(n_done),  128'(1));
      chk("p2_e0", 128'(win22[0*IW +: IW]), 128'(8'h22));
      chk("p2_e8", 128'(win22[8*IW +: IW]), 128'(8'h00));

      // Back-to-back frames
      clear_obs();
      frame(8'h00, 1'b1, 1'b0);
      frame(8'h80, 1'b1, 1'b0);
      idle(3);
      chk("p3_valid_count", 128'(n_valid), 128'(8));
      chk("p3_done_count",  128'(n_done),  128'(2));
      chk("p3_f2_e0", 128'(win22[0*IW +: IW]), 128'(8'hA2));
      chk("p3_f2_e8", 128'(win22[8*IW +: IW]), 128'(8'h80));

      // Frame truncated by in_sof at the pixel that would be (1,3)
      clear_obs();
      for (int i = 0; i < 7; i++) send(IW'((i / PPL) * 16 + (i % PPL)), i == 0);
      frame(8'h40, 1'b1, 1'b0);
      idle(3);
      chk("p4_valid_count", 128'(n_valid), 128'(4));
      chk("p4_done_count",  128'(n_done),  128'(1));
      chk("p4_first_row",   128'(first_row), 128'(2));
      chk("p4_first_col",   128'(first_col), 128'(2));
      chk("p4_e8", 128'(win22[8*IW +: IW]), 128'(8'h40));

      // Reset just after (2,2) is accepted, then resume without in_sof
      clear_obs();
      for (int i = 0; i < 11; i++) send(IW'((i / PPL) * 16 + (i % PPL)), i == 0);
      @(negedge clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      frame(8'h20, 1'b0, 1'b0);
      idle(3);
      chk("p5_valid_count", 128'(n_valid), 128'(5));
      chk("p5_done_count",  128'(n_done),  128'(1));
      chk("p5_e8", 128'(win22[8*IW +: IW]), 128'(8'h20));
      chk("sb_drained", 128'(sb.size()), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
